// File: rtl/mux_seq_pkg.sv
// Shared definitions for the mux select sequencer: state encoding,
// channel count and the channel-index type (also used by the mux bench).
package mux_seq_pkg;

    localparam int NUM_CH = 4;

    // Two-bit index of one of the four mux inputs (in0..in3).
    typedef logic [1:0] chan_t;

    // Sequencer states: IDLE waits for a run request, DWELL holds a channel.
    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

endpackage : mux_seq_pkg

// File: rtl/mux_sel_sequencer_if.sv
// Control/status bundle between a scan controller and the select sequencer.
// The master side requests the scan and programs mask/dwell; the slave side
// (the sequencer) drives the registered mux selects and status strobes.
interface mux_sel_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               enable;
    logic [3:0]         chan_mask;
    logic [DWELL_W-1:0] dwell;
    logic               sel1;
    logic               sel0;
    logic               sample_valid;
    logic               chan_switch;
    logic               busy;

    modport master (
        output enable, chan_mask, dwell,
        input  sel1, sel0, sample_valid, chan_switch, busy
    );

    modport slave (
        input  enable, chan_mask, dwell,
        output sel1, sel0, sample_valid, chan_switch, busy
    );
endinterface : mux_sel_sequencer_if

// File: rtl/mux_sel_sequencer_rr_next_chan.sv
// Round-robin channel search. Starting at cur (inclusive) or cur+1
// (exclusive), returns the first channel whose mask bit is set, wrapping 3->0.
// An exclusive search still ends on cur itself, so a lone enabled channel is
// found again.
module rr_next_chan
    import mux_seq_pkg::*;
(
    input  chan_t      cur,
    input  logic [3:0] mask,
    input  logic       inclusive,
    output chan_t      next_ch,
    output logic       found
);

    chan_t cand;
    chan_t first_off;

    assign first_off = {1'b0, ~inclusive};

    // Walk candidates from farthest to nearest so the nearest hit wins last.
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise a path that skips the assignment
    // holds the old value and synthesis infers a latch.
    always_comb begin
        next_ch = cur;
        found   = 1'b0;
        cand    = cur;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = cur + first_off + chan_t'(i);
            if (mask[cand]) begin
                next_ch = cand;
                found   = 1'b1;
            end
        end
    end

endmodule : rr_next_chan

// File: rtl/mux_sel_sequencer.sv
// Round-robin select generator for a 4:1 mux. Scans enabled channels in
// order, holds each for a programmable dwell and strobes sample_valid on the
// last dwell cycle. Every output comes straight from a flop.
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int DWELL_W  = 8,
    parameter int START_CH = 0
) (
    input  logic                clk,
    input  logic                rst,
    mux_sel_sequencer_if.slave  bus
);

    state_t             state_q, state_d;
    chan_t              ch_q, ch_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               sv_q, sv_d;
    logic               cs_q, cs_d;
    logic               busy_q, busy_d;

    logic [DWELL_W-1:0] dwell_in_eff;
    chan_t              entry_ch;
    logic               entry_found;
    chan_t              adv_ch;
    logic               adv_found;

    // A programmed dwell of zero behaves as a single-cycle dwell.
    assign dwell_in_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

    // First channel when leaving IDLE: search from START_CH, inclusive.
    rr_next_chan u_entry_search (
        .cur       (chan_t'(START_CH)),
        .mask      (bus.chan_mask),
        .inclusive (1'b1),
        .next_ch   (entry_ch),
        .found     (entry_found)
    );

    // Round-robin advance: search from the current channel + 1. Because the
    // search wraps back onto the current channel, found is low only when the
    // whole mask is clear.
    rr_next_chan u_adv_search (
        .cur       (ch_q),
        .mask      (bus.chan_mask),
        .inclusive (1'b0),
        .next_ch   (adv_ch),
        .found     (adv_found)
    );

    // Next-state and next-output logic; outputs are precomputed here so the
    // flops below present them with no input-to-output combinational path.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        sv_d    = 1'b0;
        cs_d    = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                ch_d  = '0;
                cnt_d = '0;
                if (bus.enable && entry_found) begin
                    state_d = DWELL;
                    ch_d    = entry_ch;
                    dwell_d = dwell_in_eff;
                    sv_d    = (dwell_in_eff == DWELL_W'(1));
                    cs_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            DWELL: begin
                if (!bus.enable || !adv_found) begin
                    // Abandon any partial dwell; no strobe on the exit cycle.
                    state_d = IDLE;
                    ch_d    = '0;
                    cnt_d   = '0;
                end else if (sv_q) begin
                    // Last dwell cycle: enter the next channel using the mask
                    // seen now, even if the current channel was just cleared.
                    ch_d    = adv_ch;
                    cnt_d   = '0;
                    dwell_d = dwell_in_eff;
                    sv_d    = (dwell_in_eff == DWELL_W'(1));
                    cs_d    = (adv_ch != ch_q);
                    busy_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + DWELL_W'(1);
                    sv_d   = ((cnt_q + DWELL_W'(1)) == (dwell_q - DWELL_W'(1)));
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset overriding all inputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            sv_q    <= 1'b0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            sv_q    <= sv_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.sel1         = ch_q[1];
    assign bus.sel0         = ch_q[0];
    assign bus.sample_valid = sv_q;
    assign bus.chan_switch  = cs_q;
    assign bus.busy         = busy_q;

endmodule : mux_sel_sequencer

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Round-robin select generator that sits directly upstream of the 4:1 mux and drives its sel1/sel0 inputs.
- Scans the four mux channels in order, skipping masked-off channels, and holds each selected channel for a programmable dwell time.
- Emits a sample strobe on the last dwell cycle so a downstream capture register can take the mux output.

Parameters:
- DWELL_W, 8, width of the dwell-length input. Dwell range is 1..2^DWELL_W-1 cycles; a value of 0 is treated as 1.
- START_CH, 0, first channel searched when leaving IDLE (0..3).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  scan run request, level-sensitive.
- chan_mask  input  4  per-channel enable; bit i = channel i (in0..in3).
- dwell  input  DWELL_W  cycles to hold each channel; sampled on channel entry.
- sel1  output  1  mux select MSB, registered.
- sel0  output  1  mux select LSB, registered.
- sample_valid  output  1  one-cycle pulse on the last dwell cycle of the current channel.
- chan_switch  output  1  one-cycle pulse on the first cycle of a newly entered channel.
- busy  output  1  high while in DWELL.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: state=IDLE, {sel1,sel0}=2'b00, sample_valid=0, chan_switch=0, busy=0, dwell counter=0.
- States: IDLE, DWELL.
- IDLE -> DWELL:
  - Taken when enable=1 and chan_mask!=0.
  - The next cycle shows sel = lowest enabled channel at or after START_CH (wrapping), with chan_switch=1 and busy=1.
  - Latency from enable to a valid sel is 1 cycle.
- On channel entry:
  - Latch dwell_eff = (dwell==0) ? 1 : dwell.
  - Clear the counter to 0.
- In DWELL:
  - The counter increments each cycle.
  - When counter == dwell_eff-1, assert sample_valid for that cycle.
  - On the next cycle, enter the next enabled channel: round-robin search from current+1, wrapping 3->0.
- chan_switch:
  - Pulses only when the entered channel differs from the previous one, or on entry from IDLE.
  - With a single enabled channel, the same channel re-enters with chan_switch=0 while sample_valid keeps pulsing every dwell_eff cycles.
- dwell_eff=1: sample_valid is high every cycle and sel advances every cycle.
- chan_mask changes mid-dwell:
  - The current dwell completes normally.
  - The next-channel search uses the mask value present on the sample_valid cycle.
  - If the current channel was cleared, it is still finished first.
- chan_mask==0 while in DWELL: return to IDLE on the next cycle. sel->2'b00, busy=0, no sample_valid on that exit cycle.
- enable=0 while in DWELL: return to IDLE on the next cycle. Any partial dwell is abandoned with no sample_valid; sel->2'b00.
- enable=0 and the sample_valid cycle coincide: sample_valid is still asserted that cycle, then the block goes to IDLE.
- rst mid-operation: all outputs take their reset values on the next edge, overriding all other inputs.
- Output registering: all outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package mux_seq_pkg holds:
  - the state encoding (IDLE=1'b0, DWELL=1'b1);
  - NUM_CH=4;
  - the 2-bit channel-index typedef, which the mux testbench also uses.
- Combinational sub-module rr_next_chan:
  - inputs: current channel (2b), mask (4b), search-inclusive flag;
  - outputs: next channel (2b), found (1b);
  - used both for the IDLE entry search and for the round-robin advance.

Test Plan:
- Full scan: rst 2 cycles, mask=4'b1111, dwell=3, enable=1 at cycle 0.
  - sel=0 for cycles 1-3, then 1, 2, 3 for 3 cycles each, then wraps to 0 at cycle 13.
  - sample_valid at cycles 3, 6, 9, 12.
  - chan_switch at cycles 1, 4, 7, 10, 13.
- Skip masked channels: mask=4'b1010, dwell=2.
  - sel sequence 1,1,3,3,1,1...
  - sample_valid every 2nd cycle; sel never shows 0 or 2 while busy.
- Single channel and dwell=0: mask=4'b0100, dwell=0.
  - sel=2 constantly, sample_valid=1 every cycle.
  - chan_switch only on the first cycle.
- Abort: mask=4'b1111, dwell=5, drop enable at the 3rd dwell cycle of channel 1.
  - Next cycle: sel=0, busy=0, no sample_valid for channel 1.
- Mask change mid-dwell: mask 4'b1111->4'b0001 during channel 1's dwell.
  - Channel 1 completes its full dwell with sample_valid, then sel=0 holds with chan_switch only on that entry.
- Sync reset mid-DWELL: assert rst on channel 2.
  - Next edge: all outputs zero, state IDLE.
  - With enable held high, after rst drops the block restarts at channel 0 one cycle later.
